// File: rtl/clk_gate_pkg.sv
// Shared types for the clock-gating controller: per-channel FSM states and
// the wake-counter width (enough for a wake latency of up to 15 cycles).
package clk_gate_pkg;
  typedef enum logic [1:0] {CG_ON, CG_COUNT, CG_GATED, CG_WAKE} cg_state_e;
  localparam int WCNT_W = $clog2(16);
endpackage

// File: rtl/clk_gate_cell.sv
// Behavioural model of the library integrated clock-gating cell: the enable is
// latched while clk is low, so it only affects the next full high phase.
module clk_gate_cell #(
  parameter int DRIVE = 4
) (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic gclk
);
  // DRIVE selects the library variant; a zero-drive cell would never pass a clock.
  localparam logic DRV_OK = (DRIVE > 0);

  logic en_l;

  always_latch begin
    if (!clk) en_l = en | te;
  end

  assign gclk = clk & en_l & DRV_OK;
endmodule

// File: rtl/clk_gate_ch.sv
// One gating channel: idle counting, gate decision, timed wake-up with a
// single-cycle acknowledge. All outputs are registered.
module clk_gate_ch
  import clk_gate_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              force_on,
  input  logic              busy,
  input  logic              wake_req,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              clk_en,
  output logic              gated,
  output logic              wake_ack
);
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_LAT - 1);

  cg_state_e          state_q, state_d;
  logic [IDLE_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               clk_en_q, clk_en_d;
  logic               gated_q, gated_d;
  logic               wake_ack_q, wake_ack_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    wake_ack_d = 1'b0;
    if (force_on) begin
      state_d = CG_ON;
      cnt_d   = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        CG_ON: begin
          cnt_d = '0;
          if (!busy && idle_thresh != '0) begin
            state_d = CG_COUNT;
            cnt_d   = IDLE_W'(1);
          end
        end
        CG_COUNT: begin
          if (busy || idle_thresh == '0) begin
            state_d = CG_ON;
            cnt_d   = '0;
          end else if (cnt_q >= idle_thresh) begin
            // >= keeps the count saturated if the threshold drops mid-count
            state_d = CG_GATED;
          end else begin
            cnt_d = cnt_q + IDLE_W'(1);
          end
        end
        CG_GATED: begin
          if (wake_req || busy) begin
            state_d = CG_WAKE;
            wcnt_d  = '0;
          end
        end
        CG_WAKE: begin
          if (wcnt_q == WAKE_LAST) begin
            state_d    = CG_ON;
            wcnt_d     = '0;
            cnt_d      = '0;
            wake_ack_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        default: state_d = CG_ON;
      endcase
    end
    clk_en_d = (state_d != CG_GATED);
    gated_d  = (state_d == CG_GATED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CG_ON;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      clk_en_q   <= clk_en_d;
      gated_q    <= gated_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  assign clk_en   = clk_en_q;
  assign gated    = gated_q;
  assign wake_ack = wake_ack_q;
endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel automatic clock-gating controller: one independent FSM channel
// plus one library gating cell per clock branch; test enable bypasses the gates.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2,
  parameter int DRIVEN   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tst_en,
  input  logic [N_CH*IDLE_W-1:0] cfg_idle_thresh,
  input  logic [N_CH-1:0]        cfg_force_on,
  input  logic [N_CH-1:0]        busy,
  input  logic [N_CH-1:0]        wake_req,
  output logic [N_CH-1:0]        wake_ack,
  output logic [N_CH-1:0]        clk_en,
  output logic [N_CH-1:0]        gated,
  output logic [N_CH-1:0]        clkg
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_gate_ch #(
      .IDLE_W  (IDLE_W),
      .WAKE_LAT(WAKE_LAT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .force_on   (cfg_force_on[g]),
      .busy       (busy[g]),
      .wake_req   (wake_req[g]),
      .idle_thresh(cfg_idle_thresh[g*IDLE_W +: IDLE_W]),
      .clk_en     (clk_en[g]),
      .gated      (gated[g]),
      .wake_ack   (wake_ack[g])
    );

    clk_gate_cell #(
      .DRIVE(DRIVEN)
    ) u_icg (
      .clk (clk),
      .en  (clk_en[g]),
      .te  (tst_en),
      .gclk(clkg[g])
    );
  end
endmodule
